outerprodrc_drain: RTL and testbench
====================================

Name: outerprodrc_drain

Overview:
- Downstream controller and result-drain stage for the rate-coded outer-product array.
- Sequences one outer-product pass: clear the accumulators, enable for a fixed number of unary cycles, then snapshot the ROWNUM x COLNUM result bus.
- Streams the snapshot one element per handshake, row-major, on a valid/ready port toward writeback or the next layer.

Parameters:
- ROWNUM, 2, rows of the outer-product array.
- COLNUM, 2, columns of the outer-product array.
- OUTBITWIDTH, 8, width of one accumulated product element.
- ACCCYCLE, 8, unary accumulation cycles per pass (2^(BITWIDTH-1) for BITWIDTH=4).
- SETTLE, 1, idle cycles after the enable drops before capture (upstream output register latency); legal 0..7.

Ports:
- iClk  in  1  clock.
- iRst  in  1  asynchronous active-high reset.
- iStart  in  1  start pulse; sampled only in IDLE.
- oBusy  out  1  high in every state except IDLE.
- oClr  out  1  to the array clear input; high exactly one cycle per pass.
- oEn  out  1  to the array enable input; high exactly ACCCYCLE consecutive cycles.
- iProd  in  ROWNUM*COLNUM*OUTBITWIDTH  array result bus; element k=r*COLNUM+c at [k*OUTBITWIDTH +: OUTBITWIDTH].
- oValid  out  1  output element valid.
- iReady  in  1  downstream ready.
- oData  out  OUTBITWIDTH  current element.
- oRow  out  max(1,$clog2(ROWNUM))  row index of oData.
- oCol  out  max(1,$clog2(COLNUM))  column index of oData.
- oLast  out  1  high with oValid on element ROWNUM*COLNUM-1.
- oDone  out  1  one-cycle pulse after the last element is accepted.

Behaviour:
- Reset (async assert, sync release): state IDLE; all counters, indices and the snapshot buffer are 0.
- Reset values: oBusy, oClr, oEn, oValid, oLast and oDone are 0; oData, oRow and oCol are 0.
- Reset mid-pass aborts immediately to the reset state. No partial stream resumes.
- Outputs are Moore, decoded from registered state and registers. There is no combinational path from iReady or iStart to any output.
- FSM states: IDLE, CLR, RUN, SETTLE, CAPTURE, DRAIN, DONE.
- IDLE: goes to CLR when iStart=1. Otherwise stays in IDLE.
- CLR: lasts 1 cycle with oClr=1, then goes to RUN.
- RUN: oEn=1 while a cycle counter counts 0..ACCCYCLE-1. Goes to SETTLE after ACCCYCLE cycles, or straight to CAPTURE if SETTLE=0.
- SETTLE: oEn=0 for SETTLE cycles, then goes to CAPTURE.
- CAPTURE: lasts 1 cycle; the whole iProd bus is registered into the snapshot buffer at the end of the cycle. Element index is set to 0. Goes to DRAIN.
- DRAIN: oValid=1. oData is the buffer element at the current index; oRow and oCol are the decoded index.
- DRAIN handshake: the index advances on oValid&iReady.
- DRAIN backpressure: oData, oRow, oCol and oLast hold stable while iReady=0.
- DRAIN exit: a handshake on the last element goes to DONE.
- DONE: lasts 1 cycle with oDone=1, then goes to IDLE.
- iStart outside IDLE is ignored; it is neither queued nor an error.
- Changes on iProd after CAPTURE do not affect the stream.
- Timing, with iStart high at cycle 0 edge and reset state IDLE:
  - oClr is high in cycle 1.
  - oEn is high in cycles 2..ACCCYCLE+1.
  - CAPTURE is in cycle ACCCYCLE+SETTLE+2.
  - First oValid is in cycle ACCCYCLE+SETTLE+3.
- Minimum pass length: ACCCYCLE+SETTLE+3+ROWNUM*COLNUM+1 cycles under constant iReady=1.
- Indexing: row-major with column fastest. Index wraps only via the DONE→IDLE path; it never exceeds ROWNUM*COLNUM-1.
- Widths: the cycle counter is $clog2(ACCCYCLE+1) bits and the settle counter is 3 bits.
- Elements pass through unmodified. Sign and magnitude interpretation belongs to the consumer.

Decomposition:
- Shared package outerprodrc_pkg holds:
  - the state enum (IDLE..DONE);
  - index-width helper functions (max(1,$clog2(n)));
  - the element-slice helper for the k*OUTBITWIDTH layout, shared with the array and other consumers.
- No sub-module is needed: a single module holding the FSM, the counters and the snapshot buffer.

Test Plan:
- 2x2, OUTBITWIDTH=8, ACCCYCLE=8, SETTLE=1; iProd={8'h04,8'h03,8'h02,8'h01}; iReady=1; iStart at cycle 0. Required response:
  - oClr in cycle 1; oEn in cycles 2..9; capture in cycle 11.
  - oValid in cycles 12..15 with oData 01,02,03,04.
  - (oRow,oCol) = (0,0),(0,1),(1,0),(1,1); oLast in cycle 15; oDone in cycle 16; oBusy=0 in cycle 17.
- Same setup, iReady low in cycles 12..14 and in cycle 17. Required response:
  - oData=01 holds stable through cycle 15.
  - The elements are accepted in order 01..04 with no loss or duplication.
  - oDone follows the last accepted element by one cycle.
- Same setup, iProd changed to all-FF at cycle 12 → the stream is still 01,02,03,04.
- iStart pulsed again at cycles 5 and 13 → ignored; exactly one oClr and 8 oEn cycles per pass.
- iRst asserted mid-RUN at cycle 6 → oEn=0, oBusy=0 and oValid=0 immediately (same cycle, async). A later iStart gives a full correct pass.
- ROWNUM=3, COLNUM=1, SETTLE=0: eight oEn cycles, then capture immediately. Required response: 3 elements, oCol=0 throughout, oRow=0,1,2, oLast on the third.

Source files
------------

// File: rtl/outerprodrc_drain_pkg.sv
// Shared definitions for the rate-coded outer-product array and its consumers.
//   state_e   : sequencing states of the drain controller
//   idx_w     : index width for a count of n items, never below 1 bit
//   elem_lsb  : bit offset of element k in a flat bus of w-bit elements
//               (element k = r*COLNUM + c lives at [k*w +: w])
package outerprodrc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned elem_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/outerprodrc_drain_if.sv
// Result stream from the drain stage toward writeback / the next layer.
//   oValid : element valid          (drain -> consumer)
//   iReady : consumer ready         (consumer -> drain)
//   oData  : current element        (drain -> consumer)
//   oRow   : row index of oData     (drain -> consumer)
//   oCol   : column index of oData  (drain -> consumer)
//   oLast  : final element of pass  (drain -> consumer)
interface outerprodrc_drain_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ROW_W  = 1,
    parameter int unsigned COL_W  = 1
);
    logic              oValid;
    logic              iReady;
    logic [DATA_W-1:0] oData;
    logic [ROW_W-1:0]  oRow;
    logic [COL_W-1:0]  oCol;
    logic              oLast;

    modport master (output oValid, oData, oRow, oCol, oLast, input iReady);
    modport slave  (input oValid, oData, oRow, oCol, oLast, output iReady);
endinterface

// File: rtl/outerprodrc_drain.sv
// Controller and result drain for one outer-product pass: pulse the array
// clear, enable accumulation for ACCCYCLE cycles, wait SETTLE cycles, snapshot
// the whole result bus, then stream it row-major one element per handshake.
// Ports:
//   iClk, iRst : clock, asynchronous active-high reset
//   iStart     : start pulse, sampled only while idle
//   oBusy      : high in every state except idle
//   oClr, oEn  : array clear (one cycle) and enable (ACCCYCLE cycles)
//   iProd      : array result bus, element k at [k*OUTBITWIDTH +: OUTBITWIDTH]
//   oDone      : one-cycle pulse after the last element is accepted
//   m_out      : valid/ready result stream (data, row, col, last)
// All outputs are decoded from registers only.
module outerprodrc_drain
    import outerprodrc_pkg::*;
#(
    parameter int unsigned ROWNUM      = 2,
    parameter int unsigned COLNUM      = 2,
    parameter int unsigned OUTBITWIDTH = 8,
    parameter int unsigned ACCCYCLE    = 8,
    parameter int unsigned SETTLE      = 1
) (
    input  logic                                  iClk,
    input  logic                                  iRst,
    input  logic                                  iStart,
    output logic                                  oBusy,
    output logic                                  oClr,
    output logic                                  oEn,
    input  logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0]  iProd,
    output logic                                  oDone,
    outerprodrc_drain_if.master                   m_out
);

    localparam int unsigned NELEM = ROWNUM * COLNUM;
    localparam int unsigned RW    = idx_w(ROWNUM);
    localparam int unsigned CW    = idx_w(COLNUM);
    localparam int unsigned IW    = idx_w(NELEM);
    localparam int unsigned CNTW  = $clog2(ACCCYCLE + 1);

    state_e                 state_q, state_d;
    logic [CNTW-1:0]        cyc_q, cyc_d;
    logic [2:0]             set_q, set_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [RW-1:0]          row_q, row_d;
    logic [CW-1:0]          col_q, col_d;
    logic [OUTBITWIDTH-1:0] buf_q [NELEM];
    logic [OUTBITWIDTH-1:0] buf_d [NELEM];

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            set_q   <= '0;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            buf_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            set_q   <= set_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        set_d   = set_q;
        idx_d   = idx_q;
        row_d   = row_q;
        col_d   = col_q;
        buf_d   = buf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                cyc_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cyc_q == CNTW'(ACCCYCLE - 1)) begin
                    cyc_d   = '0;
                    set_d   = '0;
                    state_d = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
                end else begin
                    cyc_d = cyc_q + CNTW'(1);
                end
            end
            ST_SETTLE: begin
                if (set_q == 3'(SETTLE - 1)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    set_d = set_q + 3'd1;
                end
            end
            ST_CAPTURE: begin
                for (int unsigned k = 0; k < NELEM; k++) begin
                    buf_d[k] = iProd[elem_lsb(k, OUTBITWIDTH) +: OUTBITWIDTH];
                end
                idx_d   = '0;
                row_d   = '0;
                col_d   = '0;
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Row/column are tracked alongside the flat index so no divider is needed.
                if (m_out.iReady) begin
                    if (idx_q == IW'(NELEM - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                        if (col_q == CW'(COLNUM - 1)) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                idx_d   = '0;
                row_d   = '0;
                col_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign oBusy        = (state_q != ST_IDLE);
    assign oClr         = (state_q == ST_CLR);
    assign oEn          = (state_q == ST_RUN);
    assign oDone        = (state_q == ST_DONE);
    assign m_out.oValid = (state_q == ST_DRAIN);
    assign m_out.oLast  = (state_q == ST_DRAIN) && (idx_q == IW'(NELEM - 1));
    assign m_out.oData  = buf_q[idx_q];
    assign m_out.oRow   = row_q;
    assign m_out.oCol   = col_q;

endmodule

// File: tb/tb_outerprodrc_drain.sv
// Directed bench for outerprodrc_drain: a 2x2 / SETTLE=1 instance and a
// 3x1 / SETTLE=0 instance share one clock. Cycle n is the interval after
// clock edge n; iStart is held during cycle 0.
module tb_outerprodrc_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start_a, busy_a, clr_a, en_a, done_a;
    logic [31:0] prod_a;
    logic        start_b, busy_b, clr_b, en_b, done_b;
    logic [23:0] prod_b;

    localparam logic [31:0] PROD_A = 32'h0403_0201;
    localparam logic [23:0] PROD_B = 24'h33_2211;

    int tests_run    = 0;
    int tests_failed = 0;

    outerprodrc_drain_if #(.DATA_W(8), .ROW_W(1), .COL_W(1)) if_a ();
    outerprodrc_drain_if #(.DATA_W(8), .ROW_W(2), .COL_W(1)) if_b ();

    outerprodrc_drain #(
        .ROWNUM(2), .COLNUM(2), .OUTBITWIDTH(8), .ACCCYCLE(8), .SETTLE(1)
    ) u_dut_a (
        .iClk(clk), .iRst(rst), .iStart(start_a), .oBusy(busy_a), .oClr(clr_a),
        .oEn(en_a), .iProd(prod_a), .oDone(done_a), .m_out(if_a)
    );

    outerprodrc_drain #(
        .ROWNUM(3), .COLNUM(1), .OUTBITWIDTH(8), .ACCCYCLE(8), .SETTLE(0)
    ) u_dut_b (
        .iClk(clk), .iRst(rst), .iStart(start_b), .oBusy(busy_b), .oClr(clr_b),
        .oEn(en_b), .iProd(prod_b), .oDone(done_b), .m_out(if_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rdy_low[c] = 1 drops iReady during cycle c. poke overwrites iProd in cycle 12.
    // restart re-pulses iStart in cycles 5 and 13.
    task automatic run_pass_a(input string name, input logic [31:0] rdy_low,
                              input bit poke, input bit restart);
        int          phase = 0;   // 0 pre-drain, 1 drain, 2 done pulse, 3 idle
        int          m_idx = 0;
        int          n_clr = 0;
        int          n_en  = 0;
        int          n_acc = 0;
        bit          finished = 1'b0;
        logic [31:0] ref_bus = PROD_A;
        prod_a      = PROD_A;
        if_a.iReady = ~rdy_low[0];
        start_a     = 1'b1;
        for (int cyc = 1; cyc <= 40 && !finished; cyc++) begin
            tick();
            start_a     = restart && (cyc == 5 || cyc == 13);
            if_a.iReady = (cyc < 32) ? ~rdy_low[cyc] : 1'b1;
            if (poke && cyc == 12) prod_a = '1;
            if (cyc == 12 && phase == 0) phase = 1;
            n_clr += int'(clr_a);
            n_en  += int'(en_a);
            check_eq($sformatf("%s clr c%0d", name, cyc), 32'(clr_a), 32'(cyc == 1));
            check_eq($sformatf("%s en c%0d", name, cyc), 32'(en_a), 32'(cyc >= 2 && cyc <= 9));
            check_eq($sformatf("%s valid c%0d", name, cyc), 32'(if_a.oValid), 32'(phase == 1));
            check_eq($sformatf("%s busy c%0d", name, cyc), 32'(busy_a), 32'(phase != 3));
            check_eq($sformatf("%s done c%0d", name, cyc), 32'(done_a), 32'(phase == 2));
            check_eq($sformatf("%s last c%0d", name, cyc), 32'(if_a.oLast),
                     32'(phase == 1 && m_idx == 3));
            if (phase == 1) begin
                check_eq($sformatf("%s data c%0d", name, cyc), 32'(if_a.oData),
                         32'(ref_bus[m_idx*8 +: 8]));
                check_eq($sformatf("%s row c%0d", name, cyc), 32'(if_a.oRow), 32'(m_idx / 2));
                check_eq($sformatf("%s col c%0d", name, cyc), 32'(if_a.oCol), 32'(m_idx % 2));
            end
            if (phase == 3) begin
                finished = 1'b1;
            end else if (phase == 2) begin
                phase = 3;
            end else if (phase == 1 && if_a.iReady) begin
                n_acc++;
                if (m_idx == 3) phase = 2;
                else m_idx++;
            end
        end
        start_a = 1'b0;
        check_eq({name, " finished"}, 32'(finished), 32'd1);
        check_eq({name, " clr count"}, 32'(n_clr), 32'd1);
        check_eq({name, " en count"}, 32'(n_en), 32'd8);
        check_eq({name, " accepted"}, 32'(n_acc), 32'd4);
    endtask

    task automatic run_pass_b();
        int          n_en = 0;
        logic [23:0] ref_bus = PROD_B;
        prod_b      = PROD_B;
        if_b.iReady = 1'b1;
        start_b     = 1'b1;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            tick();
            start_b = 1'b0;
            n_en += int'(en_b);
            check_eq($sformatf("b clr c%0d", cyc), 32'(clr_b), 32'(cyc == 1));
            check_eq($sformatf("b en c%0d", cyc), 32'(en_b), 32'(cyc >= 2 && cyc <= 9));
            check_eq($sformatf("b valid c%0d", cyc), 32'(if_b.oValid), 32'(cyc >= 11 && cyc <= 13));
            check_eq($sformatf("b last c%0d", cyc), 32'(if_b.oLast), 32'(cyc == 13));
            check_eq($sformatf("b done c%0d", cyc), 32'(done_b), 32'(cyc == 14));
            check_eq($sformatf("b busy c%0d", cyc), 32'(busy_b), 32'(cyc <= 14));
            if (cyc >= 11 && cyc <= 13) begin
                check_eq($sformatf("b data c%0d", cyc), 32'(if_b.oData),
                         32'(ref_bus[(cyc-11)*8 +: 8]));
                check_eq($sformatf("b row c%0d", cyc), 32'(if_b.oRow), 32'(cyc - 11));
                check_eq($sformatf("b col c%0d", cyc), 32'(if_b.oCol), 32'd0);
            end
        end
        check_eq("b en count", 32'(n_en), 32'd8);
    endtask

    initial begin
        rst         = 1'b1;
        start_a     = 1'b0;
        start_b     = 1'b0;
        prod_a      = PROD_A;
        prod_b      = PROD_B;
        if_a.iReady = 1'b1;
        if_b.iReady = 1'b1;
        repeat (2) tick();

        check_eq("rst busy", 32'(busy_a), 32'd0);
        check_eq("rst clr", 32'(clr_a), 32'd0);
        check_eq("rst en", 32'(en_a), 32'd0);
        check_eq("rst valid", 32'(if_a.oValid), 32'd0);
        check_eq("rst last", 32'(if_a.oLast), 32'd0);
        check_eq("rst done", 32'(done_a), 32'd0);
        check_eq("rst data", 32'(if_a.oData), 32'd0);
        check_eq("rst row", 32'(if_a.oRow), 32'd0);
        check_eq("rst col", 32'(if_a.oCol), 32'd0);
        check_eq("rst b busy", 32'(busy_b), 32'd0);

        rst = 1'b0;
        tick();

        run_pass_a("basic", 32'h0, 1'b0, 1'b0);
        run_pass_a("bp", (32'h1 << 12) | (32'h1 << 13) | (32'h1 << 14) | (32'h1 << 17),
                   1'b0, 1'b0);
        run_pass_a("poke", 32'h0, 1'b1, 1'b0);
        run_pass_a("restart", 32'h0, 1'b0, 1'b1);

        // Abort mid-RUN: outputs must drop as soon as reset asserts, before any edge.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (5) tick();
        check_eq("abort en before", 32'(en_a), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("abort en", 32'(en_a), 32'd0);
        check_eq("abort busy", 32'(busy_a), 32'd0);
        check_eq("abort valid", 32'(if_a.oValid), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        run_pass_a("after_rst", 32'h0, 1'b0, 1'b0);

        run_pass_b();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
